// File: rtl/wash_cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wash_pkg
// Purpose  : Shared types and constants for the wash-cycle controller:
//            state enum, per-mode phase times, prices, phase LED codes and
//            small helper functions (price, phase times, BCD split).
// Revision : 1.0 - initial release
// ============================================================================
package wash_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHARGE = 3'd1,
        WASH   = 3'd2,
        RINSE  = 3'd3,
        SPIN   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] MODE_QUICK  = 2'd0;
    localparam logic [1:0] MODE_STD    = 2'd1;
    localparam logic [1:0] MODE_HEAVY  = 2'd2;
    localparam logic [1:0] MODE_CUSTOM = 2'd3;

    // Phase times in seconds
    localparam logic [5:0] QUICK_WASH_S   = 6'd10;
    localparam logic [5:0] QUICK_RINSE_S  = 6'd5;
    localparam logic [5:0] QUICK_SPIN_S   = 6'd5;
    localparam logic [5:0] STD_WASH_S     = 6'd20;
    localparam logic [5:0] STD_RINSE_S    = 6'd10;
    localparam logic [5:0] STD_SPIN_S     = 6'd10;
    localparam logic [5:0] HEAVY_WASH_S   = 6'd30;
    localparam logic [5:0] HEAVY_RINSE_S  = 6'd15;
    localparam logic [5:0] HEAVY_SPIN_S   = 6'd15;
    localparam logic [5:0] CUSTOM_RINSE_S = 6'd10;
    localparam logic [5:0] CUSTOM_SPIN_S  = 6'd10;

    // Prices
    localparam logic [11:0] PRICE_QUICK       = 12'd3;
    localparam logic [11:0] PRICE_STD         = 12'd5;
    localparam logic [11:0] PRICE_HEAVY       = 12'd8;
    localparam logic [11:0] PRICE_CUSTOM_BASE = 12'd2;

    // Phase LED encodings
    localparam logic [2:0] LED_OFF   = 3'b000;
    localparam logic [2:0] LED_WASH  = 3'b001;
    localparam logic [2:0] LED_RINSE = 3'b010;
    localparam logic [2:0] LED_SPIN  = 3'b100;

    function automatic logic [11:0] price_of(input logic [1:0] mode, input logic [4:0] ct);
        case (mode)
            MODE_QUICK: price_of = PRICE_QUICK;
            MODE_STD:   price_of = PRICE_STD;
            MODE_HEAVY: price_of = PRICE_HEAVY;
            default:    price_of = PRICE_CUSTOM_BASE + 12'(ct >> 2);
        endcase
    endfunction

    function automatic logic [5:0] wash_time_of(input logic [1:0] mode, input logic [4:0] ct);
        case (mode)
            MODE_QUICK: wash_time_of = QUICK_WASH_S;
            MODE_STD:   wash_time_of = STD_WASH_S;
            MODE_HEAVY: wash_time_of = HEAVY_WASH_S;
            default:    wash_time_of = {1'b0, ct};
        endcase
    endfunction

    function automatic logic [5:0] rinse_time_of(input logic [1:0] mode);
        case (mode)
            MODE_QUICK: rinse_time_of = QUICK_RINSE_S;
            MODE_STD:   rinse_time_of = STD_RINSE_S;
            MODE_HEAVY: rinse_time_of = HEAVY_RINSE_S;
            default:    rinse_time_of = CUSTOM_RINSE_S;
        endcase
    endfunction

    function automatic logic [5:0] spin_time_of(input logic [1:0] mode);
        case (mode)
            MODE_QUICK: spin_time_of = QUICK_SPIN_S;
            MODE_STD:   spin_time_of = STD_SPIN_S;
            MODE_HEAVY: spin_time_of = HEAVY_SPIN_S;
            default:    spin_time_of = CUSTOM_SPIN_S;
        endcase
    endfunction

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        bcd_tens = 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [6:0] v);
        bcd_ones = 4'(v % 7'd10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wash_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : wash_cycle_ctrl_if
// Purpose  : Order/control bundle between the pre-selection stage (master)
//            and the wash-cycle controller (slave).
//   master drives : start, mode, custom_t, bal_in, pause, abort [, lid_open]
//   slave drives  : bal_out, busy, paused, reject, done, alarm, phase_led,
//                   rem_tens, rem_ones [, lid_lock]
//   Optional macro WASH_LID_LOCK_EN adds lid_open / lid_lock.
// Revision : 1.0 - initial release
// ============================================================================
interface wash_cycle_ctrl_if;
    import wash_pkg::*;

    logic        start;
    logic [1:0]  mode;
    logic [4:0]  custom_t;
    logic [11:0] bal_in;
    logic        pause;
    logic        abort;
    logic [11:0] bal_out;
    logic        busy;
    logic        paused;
    logic        reject;
    logic        done;
    logic        alarm;
    logic [2:0]  phase_led;
    logic [3:0]  rem_tens;
    logic [3:0]  rem_ones;
`ifdef WASH_LID_LOCK_EN
    logic        lid_open;
    logic        lid_lock;
`endif

    modport master (
`ifdef WASH_LID_LOCK_EN
        output lid_open,
        input  lid_lock,
`endif
        output start, mode, custom_t, bal_in, pause, abort,
        input  bal_out, busy, paused, reject, done, alarm,
        input  phase_led, rem_tens, rem_ones
    );

    modport slave (
`ifdef WASH_LID_LOCK_EN
        input  lid_open,
        output lid_lock,
`endif
        input  start, mode, custom_t, bal_in, pause, abort,
        output bal_out, busy, paused, reject, done, alarm,
        output phase_led, rem_tens, rem_ones
    );

endinterface
`default_nettype wire

// File: rtl/wash_cycle_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : wash_tick_gen
// Purpose  : Prescaler counting 0..TICK_CYCLES-1 while enabled; emits a
//            one-cycle tick on wrap. clr has priority over en.
//   clk, rst (async, active-low), en, clr -> tick, msb (counter MSB)
// Revision : 1.0 - initial release
// ============================================================================
module wash_tick_gen #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  en,
    input  wire  clr,
    output logic tick,
    output logic msb
);
    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign tick = en && !clr && (r_cnt == C_LAST);
    assign msb  = r_cnt[CNT_W-1];

endmodule
`default_nettype wire

// File: rtl/wash_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wash_cycle_ctrl
// Purpose  : Charges the order price, sequences WASH -> RINSE -> SPIN on a
//            1 s tick with pause/abort, then holds a timed alarm in DONE.
//   clk, rst (async, active-low), bus (wash_cycle_ctrl_if.slave)
//   Optional macro WASH_LID_LOCK_EN: lid_open forces pause and blocks start,
//   lid_lock follows busy.
// Revision : 1.0 - initial release
// ============================================================================
module wash_cycle_ctrl
    import wash_pkg::*;
#(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int ALARM_S     = 3,
    parameter int MAX_CUSTOM  = 20
) (
    input wire               clk,
    input wire               rst,
    wash_cycle_ctrl_if.slave bus
);
    localparam logic [5:0] C_MAX_CUSTOM = 6'(MAX_CUSTOM);
    localparam logic [7:0] C_ALARM_S    = 8'(ALARM_S);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_mode, w_mode_nxt;
    logic [4:0]  r_custom, w_custom_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;
    logic [11:0] r_bal, w_bal_nxt;
    logic [7:0]  r_alarm_cnt, w_alarm_nxt;
    logic        r_paused, w_paused_nxt;
    logic        r_reject, w_reject_nxt;
    logic        r_done, w_done_nxt;

    logic        w_running, w_busy, w_refuse, w_lid_open;
    logic        w_tick, w_presc_msb;
    logic [11:0] w_start_price;
    logic [6:0]  w_rem;
    logic [2:0]  w_led;

`ifdef WASH_LID_LOCK_EN
    assign w_lid_open   = bus.lid_open;
    assign bus.lid_lock = w_busy;
`else
    assign w_lid_open   = 1'b0;
`endif

    assign w_running = (r_state == WASH) || (r_state == RINSE) || (r_state == SPIN);
    assign w_busy    = w_running || (r_state == CHARGE);

    // The prescaler also times the alarm in DONE; a fresh count starts in CHARGE.
    wash_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   ((w_running && !r_paused) || (r_state == DONE)),
        .clr  (r_state == CHARGE),
        .tick (w_tick),
        .msb  (w_presc_msb)
    );

    assign w_start_price = price_of(bus.mode, bus.custom_t);
    assign w_refuse = ($signed(bus.bal_in) < $signed(w_start_price))
                   || ((bus.mode == MODE_CUSTOM) &&
                       ((bus.custom_t == 5'd0) || ({1'b0, bus.custom_t} > C_MAX_CUSTOM)))
                   || w_lid_open;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mode      <= 2'd0;
            r_custom    <= 5'd0;
            r_cnt       <= 6'd0;
            r_bal       <= 12'd0;
            r_alarm_cnt <= 8'd0;
            r_paused    <= 1'b0;
            r_reject    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode      <= w_mode_nxt;
            r_custom    <= w_custom_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bal       <= w_bal_nxt;
            r_alarm_cnt <= w_alarm_nxt;
            r_paused    <= w_paused_nxt;
            r_reject    <= w_reject_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_custom_nxt = r_custom;
        w_cnt_nxt    = r_cnt;
        w_bal_nxt    = r_bal;
        w_alarm_nxt  = r_alarm_cnt;
        w_paused_nxt = r_paused;
        w_reject_nxt = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_refuse) begin
                        w_reject_nxt = 1'b1;
                    end else begin
                        w_mode_nxt   = bus.mode;
                        w_custom_nxt = bus.custom_t;
                        w_state_nxt  = CHARGE;
                    end
                end
            end
            CHARGE: begin
                w_bal_nxt   = bus.bal_in - price_of(r_mode, r_custom);
                w_cnt_nxt   = wash_time_of(r_mode, r_custom);
                w_state_nxt = WASH;
            end
            WASH, RINSE, SPIN: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    if (bus.pause) w_paused_nxt = ~r_paused;
                    if (w_lid_open) w_paused_nxt = 1'b1;
                    if (w_tick) begin
                        if (r_cnt == 6'd1) begin
                            // Last second of this phase: hand over to the next one now.
                            case (r_state)
                                WASH: begin
                                    w_cnt_nxt   = rinse_time_of(r_mode);
                                    w_state_nxt = RINSE;
                                end
                                RINSE: begin
                                    w_cnt_nxt   = spin_time_of(r_mode);
                                    w_state_nxt = SPIN;
                                end
                                default: begin
                                    w_cnt_nxt   = 6'd0;
                                    w_alarm_nxt = C_ALARM_S;
                                    w_done_nxt  = 1'b1;
                                    w_state_nxt = DONE;
                                end
                            endcase
                        end else begin
                            w_cnt_nxt = r_cnt - 6'd1;
                        end
                    end
                end
            end
            DONE: begin
                if (w_tick) begin
                    if (r_alarm_cnt <= 8'd1) w_state_nxt = IDLE;
                    else                     w_alarm_nxt = r_alarm_cnt - 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // paused only has meaning inside the running phases
        if ((w_state_nxt != WASH) && (w_state_nxt != RINSE) && (w_state_nxt != SPIN))
            w_paused_nxt = 1'b0;
    end

    always_comb begin
        w_rem = 7'd0;
        w_led = LED_OFF;
        case (r_state)
            WASH: begin
                w_rem = {1'b0, r_cnt} + {1'b0, rinse_time_of(r_mode)} + {1'b0, spin_time_of(r_mode)};
                w_led = LED_WASH;
            end
            RINSE: begin
                w_rem = {1'b0, r_cnt} + {1'b0, spin_time_of(r_mode)};
                w_led = LED_RINSE;
            end
            SPIN: begin
                w_rem = {1'b0, r_cnt};
                w_led = LED_SPIN;
            end
            default: begin
                w_rem = 7'd0;
                w_led = LED_OFF;
            end
        endcase
    end

    assign bus.bal_out   = r_bal;
    assign bus.busy      = w_busy;
    assign bus.paused    = r_paused;
    assign bus.reject    = r_reject;
    assign bus.done      = r_done;
    assign bus.alarm     = (r_state == DONE);
    assign bus.phase_led = w_led & {3{~r_paused | w_presc_msb}};
    assign bus.rem_tens  = bcd_tens(w_rem);
    assign bus.rem_ones  = bcd_ones(w_rem);

endmodule
`default_nettype wire

// File: tb/tb_wash_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wash_cycle_ctrl
// Purpose  : Self-checking bench for wash_cycle_ctrl. A cycle-level model
//            tracks elapsed running cycles and derives phase, remaining time
//            and flags from the per-mode time/price tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wash_cycle_ctrl;
    localparam int TICK  = 4;
    localparam int ALARM = 3;
    localparam int MAXC  = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    wash_cycle_ctrl_if bus();

    wash_cycle_ctrl #(.TICK_CYCLES(TICK), .ALARM_S(ALARM), .MAX_CUSTOM(MAXC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int wash_tab  [4] = '{10, 20, 30, 0};
    int rinse_tab [4] = '{5, 10, 15, 10};
    int spin_tab  [4] = '{5, 10, 15, 10};
    int price_tab [4] = '{3, 5, 8, 0};

    // Model: phase 0 idle, 1 charge, 2 running, 3 done
    int m_ph, m_e, m_d, m_w, m_r, m_s, m_price, m_bal;
    bit m_paused, m_reject, m_done;

    function automatic int price(input int mode, input int ct);
        return (mode == 3) ? 2 + ct / 4 : price_tab[mode];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_e = 0; m_d = 0; m_bal = 0;
        m_paused = 0; m_reject = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit st, input bit pz, input bit ab);
        int mode, ct, bal;
        mode = int'(bus.mode);
        ct   = int'(bus.custom_t);
        bal  = int'($signed(bus.bal_in));
        m_reject = 0;
        m_done   = 0;
        case (m_ph)
            0: if (st) begin
                if (bal < price(mode, ct) || (mode == 3 && (ct == 0 || ct > MAXC))) begin
                    m_reject = 1;
                end else begin
                    m_w = (mode == 3) ? ct : wash_tab[mode];
                    m_r = rinse_tab[mode];
                    m_s = spin_tab[mode];
                    m_price = price(mode, ct);
                    m_ph = 1;
                end
            end
            1: begin
                m_bal = bal - m_price;
                m_ph = 2; m_e = 0; m_paused = 0;
            end
            2: if (ab) begin
                m_ph = 0; m_paused = 0;
            end else begin
                if (!m_paused) m_e++;
                if (pz) m_paused = !m_paused;
                if (m_e == TICK * (m_w + m_r + m_s)) begin
                    m_ph = 3; m_d = 0; m_done = 1; m_paused = 0;
                end
            end
            default: begin
                m_d++;
                if (m_d == TICK * ALARM) m_ph = 0;
            end
        endcase
    endtask

    task automatic check_outputs();
        int sec, rem, led;
        sec = m_e / TICK;
        rem = (m_ph == 2) ? (m_w + m_r + m_s - sec) : 0;
        led = (m_ph != 2) ? 0 : (sec < m_w) ? 1 : (sec < m_w + m_r) ? 2 : 4;
        chk("busy",     32'(bus.busy),     32'(m_ph == 1 || m_ph == 2));
        chk("paused",   32'(bus.paused),   32'(m_paused));
        chk("reject",   32'(bus.reject),   32'(m_reject));
        chk("done",     32'(bus.done),     32'(m_done));
        chk("alarm",    32'(bus.alarm),    32'(m_ph == 3));
        chk("rem_tens", 32'(bus.rem_tens), 32'(rem / 10));
        chk("rem_ones", 32'(bus.rem_ones), 32'(rem % 10));
        chk("bal_out",  32'(bus.bal_out),  32'(12'(m_bal)));
        if (!m_paused) chk("phase_led", 32'(bus.phase_led), 32'(led));
        else           chk("phase_led_blink", 32'(bus.phase_led & ~3'(led)), 32'd0);
    endtask

    task automatic cycle(input bit st, input bit pz, input bit ab);
        bus.start = st; bus.pause = pz; bus.abort = ab;
        @(posedge clk);
        model_edge(st, pz, ab);
        #1;
        bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
        check_outputs();
    endtask

    task automatic order(input int mode, input int ct, input int bal);
        bus.mode = 2'(mode); bus.custom_t = 5'(ct); bus.bal_in = 12'(bal);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic run_to_idle(input int limit, input int pause_rate);
        for (int i = 0; i < limit && m_ph != 0; i++)
            cycle(1'b0, (pause_rate > 0) && ($urandom_range(0, pause_rate - 1) == 0), 1'b0);
    endtask

    initial begin
        int mode, ct, p;
        bus.start = 0; bus.pause = 0; bus.abort = 0;
        bus.mode = 0; bus.custom_t = 0; bus.bal_in = 0;
`ifdef WASH_LID_LOCK_EN
        bus.lid_open = 0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b1;

        // Standard mode: charge, then countdown from 40
        order(1, 0, 10);
        repeat (10) cycle(0, 0, 0);
        chk("std_bal", 32'(bus.bal_out), 32'd5);
        cycle(0, 0, 1);
        repeat (2) cycle(0, 0, 0);

        // Quick mode to completion, balance exactly the price
        order(0, 0, 3);
        run_to_idle(200, 0);
        repeat (2) cycle(0, 0, 0);

        // Refusals: short balance, bad custom times, random short balances
        order(2, 0, 7);
        cycle(0, 0, 0);
        order(3, 0, 500);
        order(3, 21, 500);
        order(3, 31, 500);
        for (int k = 0; k < 4; k++) begin
            mode = $urandom_range(0, 3);
            ct   = $urandom_range(1, MAXC);
            order(mode, ct, $urandom_range(0, price(mode, ct) - 1));
            cycle(0, 0, 0);
        end

        // Custom 12 s: pause at rem 30 for 20 cycles, then resume
        order(3, 12, 100);
        for (int i = 0; i < 100 && !(m_ph == 2 && (32 - m_e / TICK) <= 30); i++) cycle(0, 0, 0);
        cycle(0, 1, 0);
        repeat (20) cycle(0, 0, 0);
        chk("pause_hold_tens", 32'(bus.rem_tens), 32'd3);
        chk("pause_hold_ones", 32'(bus.rem_ones), 32'd0);
        cycle(0, 1, 0);
        run_to_idle(300, 0);
        chk("custom_bal", 32'(bus.bal_out), 32'd95);

        // Random accepted orders with random pause pulses
        for (int k = 0; k < 3; k++) begin
            mode = $urandom_range(0, 3);
            ct   = $urandom_range(1, MAXC);
            p    = price(mode, ct);
            order(mode, ct, $urandom_range(p, 999));
            run_to_idle(800, 16);
            cycle(0, 0, 0);
        end

        // Abort together with pause during RINSE
        order(0, 0, 50);
        for (int i = 0; i < 200 && !(m_ph == 2 && m_e / TICK >= 11); i++) cycle(0, 0, 0);
        cycle(0, 1, 1);
        repeat (4) cycle(0, 0, 0);

        // Asynchronous reset in the middle of SPIN
        order(0, 0, 60);
        for (int i = 0; i < 200 && !(m_ph == 2 && m_e / TICK >= 16); i++) cycle(0, 0, 0);
        #2 rst = 1'b0;
        #1 model_reset();
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b1;
        order(1, 0, 20);
        repeat (12) cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
